// File: rtl/dm_port_arbiter.sv
// Two-master round-robin arbiter with burst lock in front of the single-port data memory.
// Latency: grant and DM access in the same cycle; read data/rvalid one cycle after the read grant.
// Backpressure: a requester holds req and its access fields until its gnt; the loser simply waits.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mX_req/we/lock/addr/wdata        requester X access (X = 0: CPU ld/st, 1: halftone DMA)
//   mX_gnt                           access performed this cycle
//   mX_rvalid/rdata                  registered read return, rdata holds until X's next read
//   DM_read/write/address/in         data memory control (driven from the winner, zero when idle)
//   DM_out                           combinational read data from the data memory
module dm_port_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              DM_read,
    output logic              DM_write,
    output logic [ADDR_W-1:0] DM_address,
    output logic [DATA_W-1:0] DM_in,
    input  logic [DATA_W-1:0] DM_out
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               m0_rvalid_q, m0_rvalid_d;
    logic               m1_rvalid_q, m1_rvalid_d;
    logic [DATA_W-1:0]  m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]  m1_rdata_q, m1_rdata_d;

    logic               gnt0, gnt1;
    logic [CNT_W-1:0]   next_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    // Winner selection and next state. A lock owner keeps priority only while it
    // still requests; otherwise plain round-robin arbitration runs in the same cycle.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        state_d     = IDLE;
        burst_cnt_d = '0;
        rr_ptr_d    = rr_ptr_q;
        next_cnt    = '0;
        m0_rvalid_d = 1'b0;
        m1_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;

        if (!rst) begin
            if (state_q == LOCK0 && m0_req && burst_cnt_q < MAX_CNT) begin
                gnt0 = 1'b1;
            end else if (state_q == LOCK1 && m1_req && burst_cnt_q < MAX_CNT) begin
                gnt1 = 1'b1;
            end else if (m0_req && m1_req) begin
                if (rr_ptr_q) gnt1 = 1'b1;
                else          gnt0 = 1'b1;
            end else if (m0_req) begin
                gnt0 = 1'b1;
            end else if (m1_req) begin
                gnt1 = 1'b1;
            end
        end

        // burst_cnt counts grants in the current burst; the grant that would
        // reach MAX_BURST is the last one and drops the lock.
        if (gnt0) begin
            rr_ptr_d = 1'b1;
            next_cnt = ((state_q == LOCK0) ? burst_cnt_q : '0) + CNT_W'(1);
            if (m0_lock && next_cnt < MAX_CNT) begin
                state_d     = LOCK0;
                burst_cnt_d = next_cnt;
            end
            m0_rvalid_d = ~m0_we;
            if (!m0_we) m0_rdata_d = DM_out;
        end else if (gnt1) begin
            rr_ptr_d = 1'b0;
            next_cnt = ((state_q == LOCK1) ? burst_cnt_q : '0) + CNT_W'(1);
            if (m1_lock && next_cnt < MAX_CNT) begin
                state_d     = LOCK1;
                burst_cnt_d = next_cnt;
            end
            m1_rvalid_d = ~m1_we;
            if (!m1_we) m1_rdata_d = DM_out;
        end
    end

    // Outputs
    always_comb begin
        m0_gnt     = gnt0;
        m1_gnt     = gnt1;
        m0_rvalid  = m0_rvalid_q;
        m1_rvalid  = m1_rvalid_q;
        m0_rdata   = m0_rdata_q;
        m1_rdata   = m1_rdata_q;
        DM_read    = 1'b0;
        DM_write   = 1'b0;
        DM_address = '0;
        DM_in      = '0;
        if (gnt0) begin
            DM_read    = ~m0_we;
            DM_write   = m0_we;
            DM_address = m0_addr;
            DM_in      = m0_wdata;
        end else if (gnt1) begin
            DM_read    = ~m1_we;
            DM_write   = m1_we;
            DM_address = m1_addr;
            DM_in      = m1_wdata;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
module tb_dm_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [9:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        DM_read, DM_write;
    logic [9:0]  DM_address;
    logic [31:0] DM_in, DM_out;

    always #5 clk = ~clk;

    dm_port_arbiter #(.DATA_W(32), .ADDR_W(10), .MAX_BURST(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .DM_read(DM_read), .DM_write(DM_write), .DM_address(DM_address),
        .DM_in(DM_in), .DM_out(DM_out)
    );

    // Data memory behind the arbiter
    function automatic logic [31:0] pat(input int a);
        return {16'hC0DE, 6'd0, a[9:0]};
    endfunction

    logic        mem_init = 1'b1;
    logic [31:0] mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        end else if (DM_write) begin
            mem[DM_address] <= DM_in;
        end
    end
    assign DM_out = mem[DM_address];

    typedef struct {
        logic        rst;
        logic        r0, w0, l0;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        r1, w1, l1;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic        eg0, eg1;
    } vec_t;

    function automatic vec_t v(input logic rs,
                               input logic r0, input logic w0, input logic l0,
                               input logic [9:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic l1,
                               input logic [9:0] a1, input logic [31:0] d1,
                               input logic eg0, input logic eg1);
        vec_t x;
        x.rst = rs;
        x.r0 = r0; x.w0 = w0; x.l0 = l0; x.a0 = a0; x.d0 = d0;
        x.r1 = r1; x.w1 = w1; x.l1 = l1; x.a1 = a1; x.d1 = d1;
        x.eg0 = eg0; x.eg1 = eg1;
        return x;
    endfunction

    int          checks = 0;
    int          failures = 0;
    logic        pend0 = 1'b0, pend1 = 1'b0;
    logic [31:0] last0 = '0, last1 = '0;
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, update the scoreboard.
    task automatic step(input vec_t x, input string tag);
        logic        er, ew;
        logic [9:0]  ea;
        logic [31:0] ed;
        rst = x.rst;
        m0_req = x.r0; m0_we = x.w0; m0_lock = x.l0; m0_addr = x.a0; m0_wdata = x.d0;
        m1_req = x.r1; m1_we = x.w1; m1_lock = x.l1; m1_addr = x.a1; m1_wdata = x.d1;
        @(negedge clk);
        er = 1'b0; ew = 1'b0; ea = '0; ed = '0;
        if (x.eg0)      begin er = ~x.w0; ew = x.w0; ea = x.a0; ed = x.d0; end
        else if (x.eg1) begin er = ~x.w1; ew = x.w1; ea = x.a1; ed = x.d1; end
        chk({tag, " m0_gnt"}, 32'(m0_gnt), 32'(x.eg0));
        chk({tag, " m1_gnt"}, 32'(m1_gnt), 32'(x.eg1));
        chk({tag, " DM_read"}, 32'(DM_read), 32'(er));
        chk({tag, " DM_write"}, 32'(DM_write), 32'(ew));
        chk({tag, " DM_address"}, 32'(DM_address), 32'(ea));
        chk({tag, " DM_in"}, DM_in, ed);
        if (!x.rst) begin
            chk({tag, " m0_rvalid"}, 32'(m0_rvalid), 32'(pend0));
            chk({tag, " m1_rvalid"}, 32'(m1_rvalid), 32'(pend1));
            if (pend0 && q0.size() > 0) last0 = q0.pop_front();
            if (pend1 && q1.size() > 0) last1 = q1.pop_front();
            chk({tag, " m0_rdata"}, m0_rdata, last0);
            chk({tag, " m1_rdata"}, m1_rdata, last1);
            pend0 = x.eg0 && !x.w0;
            pend1 = x.eg1 && !x.w1;
            if (pend0) q0.push_back(ref_mem[x.a0]);
            if (pend1) q1.push_back(ref_mem[x.a1]);
            if (x.eg0 && x.w0) ref_mem[x.a0] = x.d0;
            if (x.eg1 && x.w1) ref_mem[x.a1] = x.d1;
        end else begin
            pend0 = 1'b0; pend1 = 1'b0;
            q0.delete(); q1.delete();
            last0 = '0; last1 = '0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [$];
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);

        // reset, single-master write/read, alternation, rr reset, pending lock, lock handoff
        tbl.push_back(v(1, 1,0,0,10'h000,32'h0, 1,0,0,10'h000,32'h0, 0,0));
        tbl.push_back(v(1, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0));
        tbl.push_back(v(0, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0));
        tbl.push_back(v(0, 1,1,0,10'h010,32'hDEADBEEF, 0,0,0,10'h000,32'h0, 1,0));
        tbl.push_back(v(0, 1,0,0,10'h010,32'h0, 0,0,0,10'h000,32'h0, 1,0));
        tbl.push_back(v(0, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0));
        tbl.push_back(v(0, 1,1,0,10'h020,32'h11111111, 1,1,0,10'h021,32'h22222222, 0,1));
        tbl.push_back(v(0, 1,1,0,10'h020,32'h11111111, 1,1,0,10'h021,32'h22222222, 1,0));
        tbl.push_back(v(0, 1,0,0,10'h021,32'h0, 1,0,0,10'h020,32'h0, 0,1));
        tbl.push_back(v(0, 1,0,0,10'h021,32'h0, 1,0,0,10'h020,32'h0, 1,0));
        tbl.push_back(v(0, 1,0,0,10'h010,32'h0, 1,0,0,10'h010,32'h0, 0,1));
        tbl.push_back(v(0, 1,0,0,10'h010,32'h0, 1,0,0,10'h010,32'h0, 1,0));
        tbl.push_back(v(0, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0));
        tbl.push_back(v(0, 1,0,0,10'h020,32'h0, 0,0,0,10'h000,32'h0, 1,0));
        tbl.push_back(v(0, 1,0,0,10'h021,32'h0, 0,0,0,10'h000,32'h0, 1,0));
        tbl.push_back(v(0, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0));
        tbl.push_back(v(1, 1,0,0,10'h010,32'h0, 1,0,0,10'h020,32'h0, 0,0));
        tbl.push_back(v(0, 1,0,0,10'h010,32'h0, 1,0,0,10'h020,32'h0, 1,0));
        tbl.push_back(v(0, 0,0,0,10'h000,32'h0, 1,0,0,10'h020,32'h0, 0,1));
        tbl.push_back(v(0, 1,0,0,10'h021,32'h0, 0,0,0,10'h000,32'h0, 1,0));
        tbl.push_back(v(0, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0));
        tbl.push_back(v(0, 1,0,1,10'h010,32'h0, 1,0,0,10'h020,32'h0, 0,1));
        tbl.push_back(v(0, 1,0,1,10'h010,32'h0, 1,0,0,10'h020,32'h0, 1,0));
        tbl.push_back(v(0, 1,0,1,10'h010,32'h0, 1,0,0,10'h020,32'h0, 1,0));
        tbl.push_back(v(0, 1,0,0,10'h010,32'h0, 1,0,0,10'h020,32'h0, 1,0));
        tbl.push_back(v(0, 1,0,0,10'h010,32'h0, 1,0,0,10'h020,32'h0, 0,1));
        tbl.push_back(v(0, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0));
        tbl.push_back(v(0, 1,0,1,10'h021,32'h0, 0,0,0,10'h000,32'h0, 1,0));
        tbl.push_back(v(0, 0,0,0,10'h000,32'h0, 1,0,0,10'h021,32'h0, 0,1));
        tbl.push_back(v(0, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0));

        rst = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("row%0d", i));
            mem_init = 1'b0;
        end

        // M1 locked burst over 0x100..0x11F with M0 contending: 16 M1 grants,
        // forced release to M0, then M1 locks again for another 16.
        for (int k = 0; k < 32; k++) begin
            if (k == 16)
                step(v(0, 1,0,0,10'h010,32'h0, 1,0,1,10'(10'h100 + k),32'h0, 1,0), "burst_release");
            step(v(0, (k > 0),0,0,10'h010,32'h0, 1,0,1,10'(10'h100 + k),32'h0, 0,1),
                 $sformatf("burst_k%0d", k));
        end
        step(v(0, 1,0,0,10'h010,32'h0, 1,0,1,10'h120,32'h0, 1,0), "burst_release2");
        step(v(0, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0), "burst_idle");

        // Reset in the middle of an M1 locked read burst
        step(v(0, 0,0,0,10'h000,32'h0, 1,0,1,10'h100,32'h0, 0,1), "rstmid_a");
        step(v(0, 0,0,0,10'h000,32'h0, 1,0,1,10'h101,32'h0, 0,1), "rstmid_b");
        step(v(1, 1,0,0,10'h010,32'h0, 1,0,1,10'h102,32'h0, 0,0), "rstmid_rst");
        step(v(0, 1,0,0,10'h010,32'h0, 1,0,1,10'h102,32'h0, 1,0), "rstmid_m0first");
        step(v(0, 0,0,0,10'h000,32'h0, 1,0,1,10'h102,32'h0, 0,1), "rstmid_m1next");
        step(v(0, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0), "rstmid_idle");
        step(v(0, 0,0,0,10'h000,32'h0, 0,0,0,10'h000,32'h0, 0,0), "rstmid_idle2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
